// File: rtl/matmul_pkg.sv
// Shared definitions for the 2x2 matmul slice: element sizing and the host
// sequencer state encoding.
package matmul_pkg;

  localparam int DATA_W = 8;
  localparam int N_ELEM = 4;
  localparam int IDX_W  = $clog2(N_ELEM);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    WAIT   = 2'd2,
    DRAIN  = 2'd3
  } state_e;

endpackage

// File: rtl/matmul_host_seq.sv
// Byte-stream front end for the 2x2 matmul controller: loads A then B one
// element per accepted byte, waits for done, then streams C out.
module matmul_host_seq
  import matmul_pkg::*;
#(
  parameter int DONE_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_byte,
  output logic              busy,
  output logic              err,
  output logic              ld_en,
  output logic              ld_sel_ab,
  output logic [IDX_W-1:0]  ld_index,
  output logic [DATA_W-1:0] ld_data,
  output logic              rd_en,
  output logic [IDX_W-1:0]  rd_sel,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              mm_done
);

  localparam logic [1:0] ST_LOAD_A = LOAD_A;
  localparam logic [1:0] ST_LOAD_B = LOAD_B;
  localparam logic [1:0] ST_WAIT   = WAIT;
  localparam logic [1:0] ST_DRAIN  = DRAIN;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);

  // The wait counter only needs to reach DONE_TIMEOUT-1; with the timeout
  // disabled it saturates so the "first WAIT cycle" marker stays valid.
  localparam int              WAIT_W    = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DONE_TIMEOUT - 1);

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [WAIT_W-1:0] wait_cnt;
  logic              accept;
  logic              draining;

  assign accept   = in_valid & in_ready;
  assign draining = (state == ST_DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD_A;
      idx       <= '0;
      wait_cnt  <= '0;
      in_ready  <= 1'b0;
      err       <= 1'b0;
      ld_en     <= 1'b0;
      ld_sel_ab <= 1'b0;
      ld_index  <= '0;
      ld_data   <= '0;
    end else begin
      ld_en <= 1'b0;
      case (state)
        ST_LOAD_A, ST_LOAD_B: begin
          in_ready <= 1'b1;
          if (accept) begin
            ld_en     <= 1'b1;
            ld_sel_ab <= (state == ST_LOAD_B);
            ld_index  <= idx;
            ld_data   <= in_byte;
            idx       <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            if (idx == IDX_LAST) begin
              if (state == ST_LOAD_A) begin
                state <= ST_LOAD_B;
              end else begin
                state    <= ST_WAIT;
                in_ready <= 1'b0;
                wait_cnt <= '0;
              end
            end
          end
        end
        // A nonzero count means the final ld_en pulse has already been seen
        // by the controller, so its done level can be trusted.
        ST_WAIT: begin
          if ((wait_cnt != '0) && mm_done) begin
            state    <= ST_DRAIN;
            wait_cnt <= '0;
          end else if ((DONE_TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
            err      <= 1'b1;
            state    <= ST_LOAD_A;
            idx      <= '0;
            wait_cnt <= '0;
            in_ready <= 1'b1;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (idx == IDX_LAST) begin
              state    <= ST_LOAD_A;
              idx      <= '0;
              in_ready <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: state <= ST_LOAD_A;
      endcase
    end
  end

  assign out_valid = draining;
  assign rd_en     = draining;
  assign rd_sel    = draining ? idx : '0;
  assign out_byte  = draining ? rd_data : '0;
  assign busy      = (state != ST_LOAD_A) | (idx != '0);

endmodule

// File: tb/tb_matmul_host_seq.sv
// Self-checking bench for matmul_host_seq with a behavioural 2x2 controller
// model driving mm_done and rd_data.
module tb_matmul_host_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       busy;
  logic       err;
  logic       ld_en;
  logic       ld_sel_ab;
  logic [1:0] ld_index;
  logic [7:0] ld_data;
  logic       rd_en;
  logic [1:0] rd_sel;
  logic [7:0] rd_data;
  logic       mm_done;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  matmul_host_seq #(.DONE_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .busy(busy), .err(err),
    .ld_en(ld_en), .ld_sel_ab(ld_sel_ab), .ld_index(ld_index), .ld_data(ld_data),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data), .mm_done(mm_done)
  );

  // Controller model: latches loads, raises done a few cycles after the 8th load.
  logic [7:0] ma [4];
  logic [7:0] mb [4];
  logic [7:0] c_model [4];
  int         ld_count;
  int         done_delay;
  bit         done_enable = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      ld_count   <= 0;
      done_delay <= 0;
      mm_done    <= 1'b0;
    end else if (ld_en) begin
      if (ld_sel_ab) mb[ld_index] <= ld_data;
      else           ma[ld_index] <= ld_data;
      mm_done <= 1'b0;
      if (ld_count == 7) begin
        ld_count   <= 0;
        done_delay <= 3;
      end else begin
        ld_count <= ld_count + 1;
      end
    end else if (done_delay != 0) begin
      done_delay <= done_delay - 1;
      if (done_delay == 1) mm_done <= done_enable;
    end
  end

  always_comb begin
    logic [15:0] t;
    t = '0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        t = 16'(ma[2*r]) * 16'(mb[c]) + 16'(ma[2*r+1]) * 16'(mb[2+c]);
        c_model[2*r+c] = t[7:0];
      end
    end
  end

  assign rd_data = c_model[rd_sel];

  typedef struct packed {
    logic       ab;
    logic [1:0] idx;
    logic [7:0] data;
  } ld_rec_t;

  ld_rec_t ld_log [$];

  always @(negedge clk) begin
    if (!rst && ld_en) ld_log.push_back('{ab: ld_sel_ab, idx: ld_index, data: ld_data});
  end

  typedef struct {
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    logic [3:0][7:0] c;
    int              gap;
    int              hold;
    bit              keep;
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".in_ready"},  in_ready,  0);
    checkOutput({tag, ".out_valid"}, out_valid, 0);
    checkOutput({tag, ".busy"},      busy,      0);
    checkOutput({tag, ".err"},       err,       0);
    checkOutput({tag, ".ld_en"},     ld_en,     0);
    checkOutput({tag, ".ld_sel_ab"}, ld_sel_ab, 0);
    checkOutput({tag, ".ld_index"},  ld_index,  0);
    checkOutput({tag, ".ld_data"},   ld_data,   0);
    checkOutput({tag, ".rd_en"},     rd_en,     0);
    checkOutput({tag, ".rd_sel"},    rd_sel,    0);
    checkOutput({tag, ".out_byte"},  out_byte,  0);
  endtask

  // Offers n operand bytes (A then B); returns at the negedge after the last accept.
  task automatic applyStimulus(input vec_t v, input int n);
    int accepted = 0;
    int cyc = 0;
    ld_log.delete();
    while (accepted < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (v.gap != 0 && (cyc % 2 == 0)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_byte  = (accepted < 4) ? v.a[accepted] : v.b[accepted-4];
      end
      if (in_valid && in_ready) accepted++;
    end
    checkOutput("accept_count", accepted, n);
    @(negedge clk);
    in_valid = v.keep;
  endtask

  task automatic checkLoads(input vec_t v);
    checkOutput("ld_pulse_count", ld_log.size(), 8);
    for (int i = 0; i < 8 && i < ld_log.size(); i++) begin
      checkOutput($sformatf("ld_ab[%0d]", i),   ld_log[i].ab,   (i >= 4) ? 1 : 0);
      checkOutput($sformatf("ld_idx[%0d]", i),  ld_log[i].idx,  i % 4);
      checkOutput($sformatf("ld_data[%0d]", i), ld_log[i].data, (i < 4) ? v.a[i] : v.b[i-4]);
    end
  endtask

  task automatic collectResults(input vec_t v);
    int got = 0;
    int stall = 0;
    int cyc = 0;
    out_ready = (v.hold == 0);
    while (got < 4 && cyc < 200) begin
      if (v.keep) begin
        checkOutput("in_ready_closed", in_ready, 0);
        checkOutput("ld_en_closed", ld_en, (cyc == 0) ? 1 : 0);
      end
      if (out_valid) begin
        checkOutput("rd_en", rd_en, 1);
        if (stall < v.hold) begin
          checkOutput("hold_stable", out_byte, v.c[0]);
          stall++;
        end else begin
          out_ready = 1'b1;
          checkOutput("rd_sel", rd_sel, got);
          checkOutput($sformatf("out_byte[%0d]", got), out_byte, v.c[got]);
          got++;
        end
      end
      if (got < 4) begin
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput("drain_count", got, 4);
    checkOutput("hold_cycles", stall, v.hold);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("post_out_valid", out_valid, 0);
    checkOutput("post_rd_en", rd_en, 0);
    checkOutput("post_busy", busy, 0);
    checkOutput("post_in_ready", in_ready, 1);
    checkLoads(v);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wc;

    vecs[0] = '{a: 32'h04030201, b: 32'h08070605, c: 32'h322B1613, gap: 0, hold: 0,  keep: 1'b0};
    vecs[1] = '{a: 32'h04030201, b: 32'h08070605, c: 32'h322B1613, gap: 1, hold: 0,  keep: 1'b0};
    vecs[2] = '{a: 32'h04030201, b: 32'h08070605, c: 32'h322B1613, gap: 0, hold: 10, keep: 1'b0};
    vecs[3] = '{a: 32'h03010002, b: 32'h05020104, c: 32'h100A0208, gap: 0, hold: 0,  keep: 1'b1};
    vecs[4] = '{a: 32'h02000109, b: 32'h07040003, c: 32'h0E08071F, gap: 1, hold: 3,  keep: 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b0;

    @(negedge clk);
    @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", in_ready, 1);

    for (int i = 0; i < 4; i++) begin
      $display("[TB] frame %0d", i);
      applyStimulus(vecs[i], 8);
      collectResults(vecs[i]);
    end

    // Timeout: done never arrives, expect exactly 64 WAIT cycles then abort.
    done_enable = 1'b0;
    applyStimulus(vecs[0], 8);
    wc = 0;
    while (busy && wc < 200) begin
      if (out_valid) checkOutput("timeout_no_out", out_valid, 0);
      wc++;
      @(negedge clk);
    end
    checkOutput("timeout_wait_cycles", wc, 64);
    checkOutput("timeout_err", err, 1);
    checkOutput("timeout_busy", busy, 0);
    checkOutput("timeout_in_ready", in_ready, 1);
    checkOutput("timeout_loads", ld_log.size(), 8);
    done_enable = 1'b1;
    applyStimulus(vecs[3], 8);
    collectResults(vecs[3]);
    checkOutput("err_sticky", err, 1);

    // Reset after the 5th operand byte, then a fresh frame.
    applyStimulus(vecs[1], 5);
    checkOutput("partial_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    checkResetValues("mid_reset");
    rst = 1'b0;
    applyStimulus(vecs[4], 8);
    collectResults(vecs[4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
